// File: rtl/at_ahb5_slave_mem_pkg.sv
// Shared AHB5 types and constants for the slave memory: transfer/size encodings,
// response codes, slave FSM states and byte-lane decode helpers.
package AT_ahb5_pkg_p;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Little-endian lane enables for a transfer of the given size and byte offset
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
        case (size)
            HSIZE_BYTE: return 4'b0001 << ofs;
            HSIZE_HALF: return ofs[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] ofs);
        case (size)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ofs[0] == 1'b0;
            HSIZE_WORD: return ofs == 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/at_ahb5_slave_mem_if.sv
// AHB5 bus signals between a master (or interconnect) and one slave.
interface at_ahb5_slave_mem_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/at_ahb5_slave_mem_sram.sv
// Word-organised synchronous RAM with per-byte write enables and a registered read.
// Separate write and read addresses let a committing write and a new read share an edge.
module at_ahb5_sram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        // Read-during-write to the same word returns the old contents
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/at_ahb5_slave_mem.sv
// AHB5 SRAM slave: address decode, wait-state/ERROR FSM, byte-lane writes and
// read forwarding from a write committing on the same edge a read issues.
module at_ahb5_slave_mem
    import AT_ahb5_pkg_p::*;
#(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                AT_Hclk_i,
    input logic                AT_HReset_i,
    at_ahb5_slave_mem_if.slave bus
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    slave_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         hready_out;
    logic         hresp;

    logic          active, accept, legal, in_range;
    logic [AW-1:0] word;
    logic          rd_issue, wr_commit;

    logic          dp_valid_q, dp_write_q;
    logic [AW-1:0] dp_word_q;
    logic [3:0]    dp_mask_q;
    logic [3:0]    fwd_mask_q;
    logic [31:0]   fwd_data_q;
    logic [31:0]   fwd_bits;
    logic [31:0]   sram_rdata;

    assign active    = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
    assign accept    = bus.HSEL & bus.HREADY & hready_out & active;
    assign in_range  = (bus.HADDR[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign legal     = in_range & size_aligned(bus.HSIZE, bus.HADDR[1:0]);
    assign word      = bus.HADDR[AW+1:2];
    assign rd_issue  = accept & legal & ~bus.HWRITE;
    assign wr_commit = dp_valid_q & dp_write_q & hready_out & ~AT_HReset_i;

    always_ff @(posedge AT_Hclk_i) begin
        if (AT_HReset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hready_out = 1'b1;
        hresp      = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept) begin
                    if (!legal) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                hready_out = 1'b0;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
                state_d    = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data-phase registers only advance on the edge that ends the current data phase
    always_ff @(posedge AT_Hclk_i) begin
        if (AT_HReset_i) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_word_q  <= '0;
            dp_mask_q  <= '0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else if (hready_out) begin
            dp_valid_q <= accept & legal;
            if (accept) begin
                dp_write_q <= bus.HWRITE;
                dp_word_q  <= word;
                dp_mask_q  <= lane_mask(bus.HSIZE, bus.HADDR[1:0]);
            end
            if (rd_issue) begin
                fwd_mask_q <= (wr_commit && (dp_word_q == word)) ? dp_mask_q : '0;
                fwd_data_q <= bus.HWDATA;
            end
        end
    end

    at_ahb5_sram #(
        .DEPTH (MEM_DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (AT_Hclk_i),
        .we    (wr_commit ? dp_mask_q : 4'b0000),
        .waddr (dp_word_q),
        .wdata (bus.HWDATA),
        .re    (rd_issue),
        .raddr (word),
        .rdata (sram_rdata)
    );

    always_comb begin
        fwd_bits = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            fwd_bits[8*i +: 8] = {8{fwd_mask_q[i]}};
        end
    end

    assign bus.HRDATA    = (dp_valid_q & ~dp_write_q)
                         ? ((sram_rdata & ~fwd_bits) | (fwd_data_q & fwd_bits)) : '0;
    assign bus.HREADYOUT = hready_out;
    assign bus.HRESP     = hresp;

endmodule
